seq_cla_divider: RTL

//   Multi-cycle unsigned integer divider. It is the inverse companion of the carry-lookahead adder datapath.

---
 rtl/seq_cla_divider.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seq_cla_divider.sv
// Multi-cycle restoring unsigned divider: one quotient bit per cycle, with the
// trial subtraction done by a nibble-grouped carry-lookahead adder.
module seq_cla_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int NG = WIDTH / 4;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_msb;

  // a - b as a + ~b + 1 over WIDTH+1 bits; returns {carry_out, difference}.
  // Carry-out of 1 means no borrow (a >= b).
  function automatic logic [WIDTH+1:0] cla_sub(input logic [WIDTH:0] a,
                                               input logic [WIDTH:0] b);
    logic [WIDTH:0] bn, p, g, c, s;
    logic [NG:0]    gc;
    logic           gp, gg, cout;
    bn    = ~b;
    p     = a ^ bn;
    g     = a & bn;
    c     = '0;
    gc    = '0;
    gc[0] = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gp = &p[4*k +: 4];
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = gg | (gp & gc[k]);
    end
    // The extra MSB of the partial remainder rides on the final block carry.
    c[WIDTH] = gc[NG];
    s        = p ^ c;
    cout     = g[WIDTH] | (p[WIDTH] & c[WIDTH]);
    return {cout, s};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    r_sh  = {r_q, q_q[WIDTH-1]};
    trial = cla_sub(r_sh, {1'b0, d_q});
    // A successful trial is always below the divisor, so its MSB is zero.
    unused_trial_msb = trial[WIDTH];

    case (state_q)
      S_RUN: begin
        r_d   = trial[WIDTH+1] ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], trial[WIDTH+1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
          quot_d  = q_d;
          rem_d   = r_d;
        end
      end
      default: begin
        if (state_q == S_FIN) state_d = S_IDLE;
        if (start) begin
          d_d   = divisor;
          dbz_d = (divisor == '0);
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = dividend;
            quot_d  = '1;
            rem_d   = dividend;
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath needs no reset: it is always loaded on acceptance.
  always_ff @(posedge clk) begin
    r_q <= r_d;
    q_q <= q_d;
    d_q <= d_d;
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
